wasca_key_pio: RTL and testbench
================================

Name: wasca_key_pio

Overview:
- Avalon-MM slave input PIO for the board push-buttons and switches; the read-side counterpart of the 7-segment output PIOs.
- Signal chain per bit: 2-FF synchronizer, then per-bit debouncer, then edge detector.
- Edges are latched in an edge-capture register and raise a maskable level interrupt to the Nios/host.
- Sits on the same Avalon bus segment as the hex output PIOs; zero read latency, no wait states.

Parameters:
- WIDTH, 4: number of input bits.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced value changes; legal range 1..2^20.
- EDGE_TYPE, 1: capture edge; 0 = rising, 1 = falling, 2 = any.
- INIT_VALUE, all ones: reset value of the synchronizer and debounced registers (keys are active-low).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- address, in, 2: register select.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: read data, combinational from address and registers.
- in_port, in, WIDTH: asynchronous raw inputs.
- irq, out, 1: level interrupt, active-high.

Behaviour:
- One clock and one reset. All state updates on posedge clk. Reset is synchronous active-high: sampled only on posedge clk, and it overrides every other update in that cycle.
- Register map (word addresses):
  - 0 DATA: RO, debounced value, zero-extended.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK: RW, WIDTH bits.
  - 3 EDGECAP: read returns captured edges; a write clears every bit where writedata=1 (W1C).
- Write decode: chipselect && !write_n. Reads have no side effects. readdata upper bits are always 0.
- Reset values:
  - sync1, sync2, stable = INIT_VALUE
  - debounce counters = 0
  - IRQMASK = 0, EDGECAP = 0, irq = 0
- Synchronizer: sync1 <= in_port; sync2 <= sync1. No other logic reads sync1.
- Debouncer, per bit, counter width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Latency from an in_port step to the DATA change: 2 + DEBOUNCE_CYCLES clocks.
- Edge detect: stable_d <= stable, reset to INIT_VALUE.
  - rise = stable & ~stable_d; fall = ~stable & stable_d.
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Edge capture, per bit: EDGECAP <= (EDGECAP & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] on a write to address 3, else 0.
  - If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- The EDGECAP bit sets one clock after stable changes.
- irq = |(EDGECAP & IRQMASK), combinational from registers. It has no additional latency beyond EDGECAP/IRQMASK, and is glitch-free because it is derived only from registers.
- Writing IRQMASK while EDGECAP is set asserts irq on the following cycle. Clearing the mask deasserts irq without losing EDGECAP.
- Reset mid-debounce: counts are discarded and stable returns to INIT_VALUE. No edge is reported by the reset itself, because stable_d also resets to INIT_VALUE.
- An input held at a value different from INIT_VALUE through reset produces exactly one edge, 2+DEBOUNCE_CYCLES+1 cycles after reset release.
- Writes to DATA and to address 1 have no effect.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=1):
- Reset release with in_port=4'hF: DATA reads 0xF, EDGECAP=0, IRQMASK=0, irq=0.
- in_port[0] goes 1->0 and holds:
  - DATA reads 0xE exactly 6 clocks later.
  - EDGECAP reads 0x1 one clock after that.
  - irq stays 0 while IRQMASK=0.
- Write IRQMASK=0x1: irq rises the next cycle. Write 0x1 to address 3: EDGECAP=0 and irq=0 the next cycle.
- 3-cycle low pulse on in_port[2]: DATA stays 0xF and EDGECAP stays 0. A 4-cycle low pulse updates DATA and sets EDGECAP bit 2.
- Falling edge on bit 1 coincides with a W1C write of 0x2: EDGECAP bit 1 remains 1.
- Assert reset for 1 cycle while in_port[3] is mid-debounce (counter=2): all registers return to reset values, and no spurious EDGECAP bit is set.

Source files
------------

// File: rtl/wasca_key_pio.sv
// Avalon-MM input PIO for push-buttons/switches: 2-FF synchronizer, per-bit
// debouncer, edge detector, W1C edge-capture register and maskable level irq.
module wasca_key_pio #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE      = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] clr;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic             wr_en;
   logic             unused_wdata;

   function automatic logic [WIDTH-1:0] edge_sel(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] prev);
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      case (EDGE_TYPE)
         0:       edge_sel = rise;
         1:       edge_sel = fall;
         default: edge_sel = rise | fall;
      endcase
   endfunction

   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata[31:WIDTH];
   assign edges        = edge_sel(stable, stable_d);

   always_comb begin
      clr = '0;
      if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
   end

   // Synchronizer stage: sync1 is metastability-exposed, only sync2 feeds logic
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= INIT_VALUE;
         sync2 <= INIT_VALUE;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   // Debounce stage: counter tracks consecutive cycles sync2 disagrees with stable
   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= INIT_VALUE;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge/capture stage: a new edge beats a simultaneous W1C clear
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_d <= INIT_VALUE;
         edge_cap <= '0;
         irq_mask <= '0;
      end else begin
         stable_d <= stable;
         edge_cap <= (edge_cap & ~clr) | edges;
         if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   assign irq = |(edge_cap & irq_mask);

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = stable;
         2'd2:    readdata[WIDTH-1:0] = irq_mask;
         2'd3:    readdata[WIDTH-1:0] = edge_cap;
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_wasca_key_pio.sv
// Bench for wasca_key_pio: directed vector table for the corner cases, then
// randomized traffic checked each cycle against a history-based reference model.
module tb_wasca_key_pio;

   localparam int D = 4;
   localparam int W = 4;
   localparam logic [W-1:0] INIT = 4'hF;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [W-1:0] in_port;
   logic        irq;

   int total = 0;
   int bad   = 0;

   wasca_key_pio #(
      .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INIT_VALUE(INIT)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  inp;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   // reference model state: last D+2 sampled inputs (index 0 newest)
   logic [W-1:0] hist[$];
   logic [W-1:0] m_stable, m_stable_d, m_mask, m_cap;

   function automatic void add(logic rst, logic [3:0] inp, logic wr, logic [1:0] addr,
                               logic [31:0] wd, logic [31:0] exp_rd, logic exp_irq);
      vec_t v;
      v.rst = rst; v.inp = inp; v.wr = wr; v.addr = addr; v.wd = wd;
      v.exp_rd = exp_rd; v.exp_irq = exp_irq;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stable value changes once the input (seen two syncs late) has held the
   // other level for D consecutive samples.
   task automatic model_step();
      logic [W-1:0] clr, fall;
      bit           all_same;
      if (reset) begin
         hist.delete();
         for (int i = 0; i < D + 2; i++) hist.push_back(INIT);
         m_stable = INIT; m_stable_d = INIT; m_mask = '0; m_cap = '0;
      end else begin
         clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
         fall = m_stable_d & ~m_stable;
         m_cap = (m_cap & ~clr) | fall;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
         m_stable_d = m_stable;
         hist.push_front(in_port);
         void'(hist.pop_back());
         for (int b = 0; b < W; b++) begin
            all_same = 1'b1;
            for (int k = 3; k <= D + 1; k++)
               if (hist[k][b] != hist[2][b]) all_same = 1'b0;
            if (all_same) m_stable[b] = hist[2][b];
         end
      end
   endtask

   function automatic logic [31:0] model_read(logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_stable};
         2'd2:    return {28'd0, m_mask};
         2'd3:    return {28'd0, m_cap};
         default: return 32'd0;
      endcase
   endfunction

   task automatic cycle_and_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model_readdata", readdata, model_read(address));
      check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
   endtask

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = INIT;
      for (int i = 0; i < D + 2; i++) hist.push_back(INIT);
      m_stable = INIT; m_stable_d = INIT; m_mask = '0; m_cap = '0;

      // reset and first falling key
      add(1, 4'hF, 0, 0, 0, 32'hF, 0);
      add(0, 4'hF, 0, 3, 0, 32'h0, 0);
      add(0, 4'hF, 0, 2, 0, 32'h0, 0);
      repeat (5) add(0, 4'hE, 0, 0, 0, 32'hF, 0);
      add(0, 4'hE, 0, 0, 0, 32'hE, 0);
      add(0, 4'hE, 0, 3, 0, 32'h1, 0);
      add(0, 4'hE, 1, 2, 32'h1, 32'h1, 1);
      add(0, 4'hE, 1, 3, 32'h1, 32'h0, 0);
      add(0, 4'hE, 0, 0, 0, 32'hE, 0);
      // 3-cycle glitch on bit 2 is filtered
      repeat (3) add(0, 4'hA, 0, 0, 0, 32'hE, 0);
      repeat (5) add(0, 4'hE, 0, 0, 0, 32'hE, 0);
      add(0, 4'hE, 0, 3, 0, 32'h0, 0);
      // 4-cycle pulse on bit 2 passes
      repeat (4) add(0, 4'hA, 0, 0, 0, 32'hE, 0);
      add(0, 4'hE, 0, 0, 0, 32'hE, 0);
      add(0, 4'hE, 0, 0, 0, 32'hA, 0);
      add(0, 4'hE, 0, 3, 0, 32'h4, 0);
      add(0, 4'hE, 0, 0, 0, 32'hA, 0);
      add(0, 4'hE, 0, 0, 0, 32'hA, 0);
      add(0, 4'hE, 0, 0, 0, 32'hE, 0);
      add(0, 4'hE, 1, 3, 32'h4, 32'h0, 0);
      // bit 1 falling edge coincides with W1C of bit 1
      repeat (5) add(0, 4'hC, 0, 0, 0, 32'hE, 0);
      add(0, 4'hC, 0, 0, 0, 32'hC, 0);
      add(0, 4'hC, 1, 3, 32'h2, 32'h2, 0);
      add(0, 4'hC, 0, 3, 0, 32'h2, 0);
      // reset while bit 3 is mid-debounce, inputs held low through reset
      repeat (4) add(0, 4'h4, 0, 0, 0, 32'hC, 0);
      add(1, 4'h4, 0, 0, 0, 32'hF, 0);
      add(0, 4'h4, 0, 3, 0, 32'h0, 0);
      add(0, 4'h4, 0, 2, 0, 32'h0, 0);
      repeat (3) add(0, 4'h4, 0, 3, 0, 32'h0, 0);
      add(0, 4'h4, 0, 0, 0, 32'h4, 0);
      add(0, 4'h4, 0, 3, 0, 32'hB, 0);
      // ignored writes, mask width, unmasking existing captures
      add(0, 4'h4, 1, 1, 32'hFFFF_FFFF, 32'h0, 0);
      add(0, 4'h4, 1, 0, 32'h0, 32'h4, 0);
      add(0, 4'h4, 1, 2, 32'hFFFF_FFFF, 32'hF, 1);
      add(0, 4'h4, 1, 2, 32'h0, 32'h0, 0);
      add(0, 4'h4, 0, 3, 0, 32'hB, 0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         reset      = vecs[i].rst;
         in_port    = vecs[i].inp;
         chipselect = !vecs[i].rst;
         write_n    = !vecs[i].wr;
         address    = vecs[i].addr;
         writedata  = vecs[i].wd;
         cycle_and_check();
         check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      end

      // randomized traffic: slowly toggling keys, random bus ops, rare resets
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
         chipselect = $urandom_range(0, 1) == 1;
         write_n    = $urandom_range(0, 3) != 0;
         address    = 2'($urandom_range(0, 3));
         writedata  = $urandom;
         cycle_and_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
